// File: rtl/crash_detect_pkg.sv
// crash_detect_pkg: shared settings for the collision stage.
// Crash bit indices, FSM state encodings, screen/paddle geometry defaults
// and the saturating score helper.
package crash_detect_pkg;

   // Crash vector bit positions: {left,right,up,down}
   localparam int CRASH_LEFT  = 3;
   localparam int CRASH_RIGHT = 2;
   localparam int CRASH_UP    = 1;
   localparam int CRASH_DOWN  = 0;

   // Screen and paddle geometry defaults
   localparam int SCREEN_RIGHT  = 639;
   localparam int SCREEN_BOTTOM = 479;
   localparam int BALL_SIZE     = 8;
   localparam int PADDLE_L_X    = 16;
   localparam int PADDLE_R_X    = 616;
   localparam int PADDLE_W      = 8;
   localparam int PADDLE_H      = 64;
   localparam int HOLDOFF       = 4;
   localparam int WIN_SCORE     = 9;

   // Counter width able to hold HOLDOFF (always at least one bit)
   localparam int HOLD_W = $clog2(HOLDOFF + 2);

   // Game FSM encodings
   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_MISS = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   // Score increment that sticks at 15 instead of wrapping
   function automatic logic [3:0] score_inc(input logic [3:0] s);
      return (s == 4'd15) ? 4'd15 : (s + 4'd1);
   endfunction

endpackage

// File: rtl/crash_holdoff.sv
// crash_holdoff: turns one raw contact bit into a registered one-cycle
// pulse, then masks that bit for HOLDOFF cycles with a down-counter.
// 'fire' is the combinational "this edge will pulse" strobe so the
// parent can qualify events on the exact cycle the bit fires.
module crash_holdoff
   import crash_detect_pkg::*;
#(
   parameter int HLD = HOLDOFF
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic srst,
   input  logic raw,
   output logic fire,
   output logic pulse
);

   localparam int CW = $clog2(HLD + 2);
   localparam logic [CW-1:0] HLD_LOAD = CW'(HLD);

   logic [CW-1:0] cnt_r;
   logic          pulse_r;

   // Contact passes only while the mask counter is idle
   always_comb begin
      fire = 1'b0;
      if (cnt_r == {CW{1'b0}}) begin
         fire = raw;
      end else begin
         fire = 1'b0;
      end
   end

   // Pulse register and holdoff down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CW{1'b0}};
         pulse_r <= 1'b0;
      end else if (srst) begin
         cnt_r   <= {CW{1'b0}};
         pulse_r <= 1'b0;
      end else if (fire) begin
         cnt_r   <= HLD_LOAD;
         pulse_r <= 1'b1;
      end else begin
         pulse_r <= 1'b0;
         if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/crash_detect.sv
// crash_detect: collision stage ahead of the ball mover. Produces the
// registered crash vector {left,right,up,down} with per-bit holdoff.
// Optional macro CRASH_SCORE_EN adds paddle hit/miss classification,
// per-player scores and the PLAY/MISS/OVER game FSM; without it every
// edge is a plain wall and the score outputs are tied low.
module crash_detect
   import crash_detect_pkg::*;
(
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic [9:0] iBall_x,
   input  logic [9:0] iBall_y,
   input  logic [9:0] iPaddle_l_y,
   input  logic [9:0] iPaddle_r_y,
   input  logic       iRestart,
   output logic [3:0] oCrash,
   output logic [3:0] oScore_l,
   output logic [3:0] oScore_r,
   output logic       oMiss,
   output logic       oGame_over
);

   // 11-bit geometry so ball+size sums never truncate
   localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
   localparam logic [10:0] RIGHT_LM = 11'(SCREEN_RIGHT);
   localparam logic [10:0] BOT_LM   = 11'(SCREEN_BOTTOM);

   logic [10:0] ball_xr_s;
   logic [10:0] ball_yb_s;
   logic        left_wall_s;
   logic        right_wall_s;
   logic        top_wall_s;
   logic        bottom_wall_s;
   logic        raw_left_s;
   logic        raw_right_s;
   logic [3:0]  raw_s;
   logic [3:0]  fire_s;
   logic [3:0]  crash_s;
   logic        restart_s;

   // Wall contacts; 2 px deep windows, low edges also catch 10-bit wrap
   always_comb begin
      ball_xr_s     = {1'b0, iBall_x} + BALL_W;
      ball_yb_s     = {1'b0, iBall_y} + BALL_W;
      left_wall_s   = (iBall_x <= 10'd1) || (iBall_x >= 10'd1020);
      right_wall_s  = (ball_xr_s >= RIGHT_LM);
      top_wall_s    = (iBall_y <= 10'd1) || (iBall_y >= 10'd1020);
      bottom_wall_s = (ball_yb_s >= BOT_LM);
   end

   // A wrapped position also satisfies the far-edge test, so the near
   // edge (left, up) wins when both evaluate true
   always_comb begin
      raw_s              = 4'd0;
      raw_s[CRASH_LEFT]  = raw_left_s;
      raw_s[CRASH_RIGHT] = raw_right_s & ~raw_left_s;
      raw_s[CRASH_UP]    = top_wall_s;
      raw_s[CRASH_DOWN]  = bottom_wall_s & ~top_wall_s;
   end

   for (genvar b = 0; b < 4; b++) begin : g_hold
      crash_holdoff #(.HLD(HOLDOFF)) u_hold (
         .clk   (iVGA_CLK),
         .rst_n (iRST_n),
         .srst  (restart_s),
         .raw   (raw_s[b]),
         .fire  (fire_s[b]),
         .pulse (crash_s[b])
      );
   end

   assign oCrash = crash_s;

`ifdef CRASH_SCORE_EN

   localparam logic [10:0]       PL_LO     = 11'(PADDLE_L_X + PADDLE_W - 2);
   localparam logic [10:0]       PL_HI     = 11'(PADDLE_L_X + PADDLE_W);
   localparam logic [10:0]       PR_LO     = 11'(PADDLE_R_X);
   localparam logic [10:0]       PR_HI     = 11'(PADDLE_R_X + 2);
   localparam logic [10:0]       PAD_H     = 11'(PADDLE_H);
   localparam logic [HOLD_W-1:0] MISS_LAST = HOLD_W'(HOLDOFF - 1);
   localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

   logic              overlap_l_s;
   logic              overlap_r_s;
   logic              hit_l_s;
   logic              hit_r_s;
   logic              miss_left_s;
   logic              miss_right_s;
   logic              unused_s;
   state_t            state_r;
   logic [HOLD_W-1:0] miss_cnt_r;
   logic [3:0]        score_l_r;
   logic [3:0]        score_r_r;
   logic              miss_pulse_r;
   logic              game_over_r;

   assign restart_s = iRestart;
   assign unused_s  = ^fire_s[1:0];

   // Paddle overlap/hit and miss classification on the firing cycle
   always_comb begin
      overlap_l_s  = (ball_yb_s > {1'b0, iPaddle_l_y}) &&
                     ({1'b0, iBall_y} < ({1'b0, iPaddle_l_y} + PAD_H));
      overlap_r_s  = (ball_yb_s > {1'b0, iPaddle_r_y}) &&
                     ({1'b0, iBall_y} < ({1'b0, iPaddle_r_y} + PAD_H));
      hit_l_s      = overlap_l_s && ({1'b0, iBall_x} >= PL_LO) &&
                     ({1'b0, iBall_x} <= PL_HI);
      hit_r_s      = overlap_r_s && (ball_xr_s >= PR_LO) && (ball_xr_s <= PR_HI);
      raw_left_s   = left_wall_s | hit_l_s;
      raw_right_s  = right_wall_s | hit_r_s;
      miss_left_s  = fire_s[CRASH_LEFT] & left_wall_s & ~overlap_l_s;
      miss_right_s = fire_s[CRASH_RIGHT] & right_wall_s & ~overlap_r_s;
   end

   // Game FSM with score counters; restart outranks a same-cycle miss
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_r      <= ST_PLAY;
         miss_cnt_r   <= {HOLD_W{1'b0}};
         score_l_r    <= 4'd0;
         score_r_r    <= 4'd0;
         miss_pulse_r <= 1'b0;
         game_over_r  <= 1'b0;
      end else if (iRestart) begin
         state_r      <= ST_PLAY;
         miss_cnt_r   <= {HOLD_W{1'b0}};
         score_l_r    <= 4'd0;
         score_r_r    <= 4'd0;
         miss_pulse_r <= 1'b0;
         game_over_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_PLAY: begin
               if (miss_left_s || miss_right_s) begin
                  if (miss_left_s) begin
                     score_r_r <= score_inc(score_r_r);
                  end
                  if (miss_right_s) begin
                     score_l_r <= score_inc(score_l_r);
                  end
                  miss_pulse_r <= 1'b1;
                  miss_cnt_r   <= {HOLD_W{1'b0}};
                  state_r      <= ST_MISS;
               end else begin
                  miss_pulse_r <= 1'b0;
               end
            end
            ST_MISS: begin
               miss_pulse_r <= 1'b0;
               if (miss_cnt_r == MISS_LAST) begin
                  miss_cnt_r <= {HOLD_W{1'b0}};
                  if ((score_l_r == WIN) || (score_r_r == WIN)) begin
                     state_r     <= ST_OVER;
                     game_over_r <= 1'b1;
                  end else begin
                     state_r <= ST_PLAY;
                  end
               end else begin
                  miss_cnt_r <= miss_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
               end
            end
            ST_OVER: begin
               miss_pulse_r <= 1'b0;
               game_over_r  <= 1'b1;
            end
            default: begin
               state_r      <= ST_PLAY;
               miss_pulse_r <= 1'b0;
               game_over_r  <= 1'b0;
            end
         endcase
      end
   end

   assign oScore_l   = score_l_r;
   assign oScore_r   = score_r_r;
   assign oMiss      = miss_pulse_r;
   assign oGame_over = game_over_r;

`else

   logic unused_s;

   assign restart_s = 1'b0;
   assign unused_s  = ^{iRestart, iPaddle_l_y, iPaddle_r_y, fire_s};

   // Plain walls on the side edges
   always_comb begin
      raw_left_s  = left_wall_s;
      raw_right_s = right_wall_s;
   end

   assign oScore_l   = 4'd0;
   assign oScore_r   = 4'd0;
   assign oMiss      = 1'b0;
   assign oGame_over = 1'b0;

`endif

endmodule

// File: tb/tb_crash_detect.sv
// tb_crash_detect: scoreboard bench for crash_detect. Each driven cycle
// pushes the expected outputs computed by a behavioural model of the
// block; they are popped and compared #1 after the next rising edge.
// Follows the CRASH_SCORE_EN setting of the build.
module tb_crash_detect;

   logic       iVGA_CLK = 1'b0;
   logic       iRST_n   = 1'b1;
   logic [9:0] iBall_x  = 10'd300;
   logic [9:0] iBall_y  = 10'd300;
   logic [9:0] iPaddle_l_y = 10'd200;
   logic [9:0] iPaddle_r_y = 10'd200;
   logic       iRestart = 1'b0;
   logic [3:0] oCrash;
   logic [3:0] oScore_l;
   logic [3:0] oScore_r;
   logic       oMiss;
   logic       oGame_over;

   crash_detect dut (
      .iVGA_CLK    (iVGA_CLK),
      .iRST_n      (iRST_n),
      .iBall_x     (iBall_x),
      .iBall_y     (iBall_y),
      .iPaddle_l_y (iPaddle_l_y),
      .iPaddle_r_y (iPaddle_r_y),
      .iRestart    (iRestart),
      .oCrash      (oCrash),
      .oScore_l    (oScore_l),
      .oScore_r    (oScore_r),
      .oMiss       (oMiss),
      .oGame_over  (oGame_over)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   typedef struct packed {
      logic [3:0] crash;
      logic [3:0] sl;
      logic [3:0] sr;
      logic       miss;
      logic       over;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // model state
   int   m_hold[4];
   int   m_state;   // 0 PLAY, 1 MISS, 2 OVER
   int   m_cnt;
   int   m_sl;
   int   m_sr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) m_hold[b] = 0;
      m_state = 0;
      m_cnt   = 0;
      m_sl    = 0;
      m_sr    = 0;
      sb_q.delete();
   endtask

   task automatic do_reset();
      iRST_n = 1'b0;
      #2;
      check_val("rst_crash", {28'd0, oCrash}, 32'd0);
      check_val("rst_score_l", {28'd0, oScore_l}, 32'd0);
      check_val("rst_score_r", {28'd0, oScore_r}, 32'd0);
      check_val("rst_miss", {31'd0, oMiss}, 32'd0);
      check_val("rst_over", {31'd0, oGame_over}, 32'd0);
      model_reset();
      #4;
      iRST_n = 1'b1;
   endtask

   task automatic drive_cycle(input logic [9:0] bx, input logic [9:0] by,
                              input logic [9:0] ply, input logic [9:0] pry,
                              input logic rs);
      logic [10:0] x11, y11, xs, ys;
      logic        lw, rw, tw, bw, ovl, ovr, hl, hr, ml, mr, rs_eff;
      logic [3:0]  raw, fire;
      exp_t        e, got;
      iBall_x = bx; iBall_y = by; iPaddle_l_y = ply; iPaddle_r_y = pry; iRestart = rs;
      x11 = {1'b0, bx}; y11 = {1'b0, by};
      xs  = x11 + 11'd8; ys = y11 + 11'd8;
      lw  = (bx <= 10'd1) || (bx >= 10'd1020);
      rw  = (xs >= 11'd639);
      tw  = (by <= 10'd1) || (by >= 10'd1020);
      bw  = (ys >= 11'd479);
      ovl = (ys > {1'b0, ply}) && (y11 < ({1'b0, ply} + 11'd64));
      ovr = (ys > {1'b0, pry}) && (y11 < ({1'b0, pry} + 11'd64));
      hl  = ovl && (x11 >= 11'd22) && (x11 <= 11'd24);
      hr  = ovr && (xs >= 11'd616) && (xs <= 11'd618);
`ifdef CRASH_SCORE_EN
      rs_eff = rs;
      raw[3] = lw | hl;
      raw[2] = (rw | hr) & ~raw[3];
`else
      rs_eff = 1'b0;
      raw[3] = lw;
      raw[2] = rw & ~lw;
`endif
      raw[1] = tw;
      raw[0] = bw & ~tw;
      e = '0;
      for (int b = 0; b < 4; b++) fire[b] = raw[b] && (m_hold[b] == 0);
      if (rs_eff) begin
         for (int b = 0; b < 4; b++) m_hold[b] = 0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (fire[b]) begin
               e.crash[b] = 1'b1;
               m_hold[b]  = 4;
            end else if (m_hold[b] != 0) begin
               m_hold[b]--;
            end
         end
      end
      ml = fire[3] && lw && !ovl;
      mr = fire[2] && rw && !ovr;
`ifdef CRASH_SCORE_EN
      if (rs_eff) begin
         m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0;
      end else if (m_state == 0) begin
         if (ml || mr) begin
            if (ml && m_sr < 15) m_sr++;
            if (mr && m_sl < 15) m_sl++;
            e.miss  = 1'b1;
            m_state = 1;
            m_cnt   = 0;
         end
      end else if (m_state == 1) begin
         if (m_cnt == 3) begin
            m_cnt   = 0;
            m_state = (m_sl == 9 || m_sr == 9) ? 2 : 0;
         end else begin
            m_cnt++;
         end
      end
      e.sl   = 4'(m_sl);
      e.sr   = 4'(m_sr);
      e.over = (m_state == 2);
`else
      ml = ml; mr = mr;
`endif
      sb_q.push_back(e);
      @(posedge iVGA_CLK);
      #1;
      got = sb_q.pop_front();
      check_val("crash", {28'd0, oCrash}, {28'd0, got.crash});
      check_val("score_l", {28'd0, oScore_l}, {28'd0, got.sl});
      check_val("score_r", {28'd0, oScore_r}, {28'd0, got.sr});
      check_val("miss", {31'd0, oMiss}, {31'd0, got.miss});
      check_val("game_over", {31'd0, oGame_over}, {31'd0, got.over});
      iRestart = 1'b0;
   endtask

   task automatic idle(input int n, input logic [9:0] ply, input logic [9:0] pry);
      for (int i = 0; i < n; i++) drive_cycle(10'd300, 10'd300, ply, pry, 1'b0);
   endtask

   initial begin
      #1;
      do_reset();

      // top wall: y stepping down to 0, then parked in contact
      for (int y = 10; y >= 0; y -= 2) drive_cycle(10'd300, 10'(y), 10'd200, 10'd200, 1'b0);
      for (int i = 0; i < 5; i++) drive_cycle(10'd300, 10'd0, 10'd200, 10'd200, 1'b0);
      idle(2, 10'd200, 10'd200);

      // bottom wall window
      for (int y = 466; y <= 472; y += 2) drive_cycle(10'd300, 10'(y), 10'd200, 10'd200, 1'b0);
      idle(5, 10'd200, 10'd200);

      // left paddle hit
      for (int x = 30; x >= 24; x -= 2) drive_cycle(10'(x), 10'd220, 10'd200, 10'd200, 1'b0);
      drive_cycle(10'd26, 10'd220, 10'd200, 10'd200, 1'b0);
      idle(5, 10'd200, 10'd200);

      // right paddle hit
      for (int x = 602; x <= 608; x += 2) drive_cycle(10'(x), 10'd300, 10'd200, 10'd280, 1'b0);
      idle(5, 10'd200, 10'd280);

      // left miss
      for (int x = 4; x >= 0; x -= 2) drive_cycle(10'(x), 10'd300, 10'd0, 10'd200, 1'b0);
      drive_cycle(10'd0, 10'd300, 10'd0, 10'd200, 1'b0);
      idle(6, 10'd0, 10'd200);

      // corner with 10-bit wrap on both axes
      drive_cycle(10'd1022, 10'd1022, 10'd200, 10'd200, 1'b0);
      idle(6, 10'd200, 10'd200);

      // restart clears scores
      drive_cycle(10'd300, 10'd300, 10'd200, 10'd200, 1'b1);
      idle(2, 10'd200, 10'd200);

      // nine right-wall misses end the game
      for (int k = 0; k < 9; k++) begin
         drive_cycle(10'd631, 10'd300, 10'd0, 10'd0, 1'b0);
         idle(6, 10'd0, 10'd0);
      end
      // further miss while OVER leaves scores frozen
      drive_cycle(10'd632, 10'd300, 10'd0, 10'd0, 1'b0);
      idle(6, 10'd0, 10'd0);
      // restart leaves OVER
      drive_cycle(10'd300, 10'd300, 10'd0, 10'd0, 1'b1);
      idle(2, 10'd0, 10'd0);

      // reset in the middle of MISS
      drive_cycle(10'd0, 10'd300, 10'd0, 10'd0, 1'b0);
      idle(2, 10'd0, 10'd0);
      do_reset();
      drive_cycle(10'd0, 10'd300, 10'd0, 10'd0, 1'b0);
      idle(6, 10'd0, 10'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crash_detect.md
Name: crash_detect

Overview:
- Collision stage directly upstream of the ball mover.
- Consumes the registered ball position and both paddle positions, and produces the 4-bit crash vector {left,right,up,down} that the ball mover uses to flip direction.
- Also classifies side contacts as paddle hit or miss, keeps per-player scores, and runs a PLAY/MISS/OVER game FSM.

Parameters:
- SCREEN_RIGHT, 639, rightmost pixel column.
- SCREEN_BOTTOM, 479, bottom pixel row.
- BALL_SIZE, 8, ball square edge in pixels.
- PADDLE_L_X, 16, left paddle left edge.
- PADDLE_R_X, 616, right paddle left edge.
- PADDLE_W, 8, paddle width in pixels.
- PADDLE_H, 64, paddle height in pixels.
- HOLDOFF, 4, cycles a crash bit is suppressed after it fires.
- WIN_SCORE, 9, score that ends the game.

Ports:
- iVGA_CLK  in  1  pixel clock.
- iRST_n  in  1  async active-low reset.
- iBall_x  in  10  ball left edge.
- iBall_y  in  10  ball top edge.
- iPaddle_l_y  in  10  left paddle top edge.
- iPaddle_r_y  in  10  right paddle top edge.
- iRestart  in  1  one-cycle pulse; clears scores and re-enters PLAY.
- oCrash  out  4  [3]=left [2]=right [1]=up [0]=down, registered one-cycle pulses.
- oScore_l  out  4  left player score.
- oScore_r  out  4  right player score.
- oMiss  out  1  one-cycle pulse when a miss is counted.
- oGame_over  out  1  high in OVER.

Behaviour:
- Reset and clocking: one clock, iVGA_CLK. Reset is asynchronous, active-low on iRST_n. On reset, all outputs are 0, the FSM enters PLAY, and the holdoff counters are 0.
- Latency: contact is evaluated combinationally from the inputs and registered onto oCrash one cycle later. The ball moves 2 px/clk, so every detection window is 2 px deep so that no contact can be skipped.
- Left wall: iBall_x <= 1, or iBall_x >= 1020 (underflow wrap of the 10-bit position).
- Right wall: iBall_x + BALL_SIZE >= SCREEN_RIGHT.
- Top: iBall_y <= 1, or iBall_y >= 1020.
- Bottom: iBall_y + BALL_SIZE >= SCREEN_BOTTOM.
- Left paddle hit:
  - horizontal: iBall_x in [PADDLE_L_X+PADDLE_W-2, PADDLE_L_X+PADDLE_W];
  - vertical overlap: iBall_y + BALL_SIZE > iPaddle_l_y and iBall_y < iPaddle_l_y + PADDLE_H.
- Right paddle hit: iBall_x + BALL_SIZE in [PADDLE_R_X, PADDLE_R_X+2], with the same vertical overlap rule against iPaddle_r_y.
- Side crash bits: left = left wall OR left paddle hit; right likewise.
- Width rule: sums are computed in 11 bits so they do not truncate.
- Holdoff: when a bit fires, the same bit is masked for HOLDOFF cycles. Masking is per bit and independent, so other bits are unaffected.
- Simultaneous contacts: corner contacts (e.g. left+up) assert both bits in the same cycle. Left and right are mutually exclusive by geometry; if both evaluate true, left wins.
- Miss: a left-wall contact with no left-paddle overlap, or the mirror case on the right. A miss is counted only in PLAY and only on the cycle its crash bit fires.
- FSM, PLAY state:
  - a miss on the left wall increments oScore_r;
  - a miss on the right wall increments oScore_l;
  - either miss pulses oMiss and moves to MISS.
- FSM, MISS state: held for HOLDOFF cycles, during which further misses are ignored. Then:
  - if either score == WIN_SCORE, go to OVER;
  - otherwise go to PLAY.
- FSM, OVER state: scores are frozen and oGame_over = 1. Crash bits are still generated so the ball keeps bouncing.
- iRestart: valid in any state and takes priority over a same-cycle miss. It clears the scores, oMiss and the holdoff counters, and enters PLAY.
- Score saturation: scores saturate at 15 and never wrap.
- Reset mid-MISS: returns immediately to the reset values.

Optional Feature:
- Macro: CRASH_SCORE_EN.
- Defined: miss classification, score counters, FSM, oMiss and oGame_over operate as described above.
- Undefined:
  - all four edges act as plain walls and paddle checks are removed;
  - oScore_l, oScore_r, oMiss and oGame_over are tied to 0;
  - iRestart is ignored;
  - holdoff still applies.

Decomposition:
- Shared settings include file holds:
  - crash bit indices (CRASH_LEFT=3, CRASH_RIGHT=2, CRASH_UP=1, CRASH_DOWN=0);
  - state encodings (ST_PLAY, ST_MISS, ST_OVER);
  - screen and paddle geometry defaults.
- Sub-module crash_holdoff, instantiated 4x: raw contact in, pulse out, internal down-counter implementing the HOLDOFF mask.

Test Plan:
- Top wall: reset, iBall_y stepping 10,8,…,0 with x = 300 -> oCrash = 4'b0010 one cycle after y = 0, no repeat for 4 cycles, other bits 0.
- Left paddle hit: iPaddle_l_y = 200, iBall_y = 220, iBall_x stepping 30,28,26,24 -> oCrash[3] pulses after x = 24, scores stay 0, oMiss = 0.
- Left miss: iPaddle_l_y = 0, iBall_y = 300, iBall_x reaches 0 -> oCrash[3] = 1, oScore_r = 1, oMiss pulses once, FSM in MISS 4 cycles, then PLAY.
- Corner and wrap: iBall_x = 1022, iBall_y = 1022 -> oCrash = 4'b1010 in the same cycle.
- Game over and restart: drive 9 right-wall misses -> oScore_l = 9, oGame_over = 1; a further miss leaves scores unchanged; iRestart pulse -> scores 0, oGame_over = 0 next cycle.
- Reset mid-MISS: assert iRST_n = 0 during MISS -> all outputs 0 asynchronously, FSM in PLAY after release.
